// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states, default width
// and the bit-counter sizing helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 32'sd8;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int clog2(input int value);
    int res;
    res = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        res = i + 32'sd1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // The counter must be able to hold every bit index of the operand.
  function automatic int cnt_width(input int width);
    return clog2(width + 32'sd1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of serial_subtractor. The overflow signal exists only
// when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;
`endif

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
    input  overflow,
`endif
    input  borrow
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output overflow,
`endif
    output borrow
  );

endinterface

// File: rtl/serial_subtractor_half_subtractor.sv
// One-bit half subtractor: x - y giving a difference bit and a borrow-out.
// Two of these plus an OR form a full subtractor cell.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first, registered borrow chain).
// Define SERIAL_SUB_OVERFLOW_EN to add the signed overflow output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_r, state_s;
  logic [WIDTH-1:0]   a_r, a_s;
  logic [WIDTH-1:0]   b_r, b_s;
  logic [WIDTH-1:0]   res_r, res_s;
  logic [WIDTH-1:0]   res_shift_s;
  logic               bin_r, bin_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic [WIDTH-1:0]   diff_r, diff_s;
  logic               borrow_r, borrow_s;
  logic               d0_s, bo0_s, d_s, bo1_s, bout_s;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic               a_msb_r, a_msb_s;
  logic               b_msb_r, b_msb_s;
  logic               ovf_r, ovf_s;
`endif

  half_subtractor u_hs_ab (
    .x  (a_r[0]),
    .y  (b_r[0]),
    .d  (d0_s),
    .bo (bo0_s)
  );

  half_subtractor u_hs_bin (
    .x  (d0_s),
    .y  (bin_r),
    .d  (d_s),
    .bo (bo1_s)
  );

  assign bout_s = bo0_s | bo1_s;

  // New difference bit enters at the MSB so the LSB-first result ends aligned.
  always_comb begin
    res_shift_s              = res_r >> 1;
    res_shift_s[WIDTH-1]     = d_s;
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_s  = state_r;
    a_s      = a_r;
    b_s      = b_r;
    res_s    = res_r;
    bin_s    = bin_r;
    cnt_s    = cnt_r;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    diff_s   = diff_r;
    borrow_s = borrow_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
    a_msb_s  = a_msb_r;
    b_msb_s  = b_msb_r;
    ovf_s    = ovf_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = SHIFT;
          a_s     = bus.a;
          b_s     = bus.b;
          res_s   = '0;
          bin_s   = 1'b0;
          cnt_s   = '0;
          busy_s  = 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
          a_msb_s = bus.a[WIDTH-1];
          b_msb_s = bus.b[WIDTH-1];
`endif
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        a_s   = a_r >> 1;
        b_s   = b_r >> 1;
        res_s = res_shift_s;
        bin_s = bout_s;
        cnt_s = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_W'(WIDTH - 1)) begin
          state_s  = DONE;
          diff_s   = res_shift_s;
          borrow_s = bout_s;
          done_s   = 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_s    = (a_msb_r != b_msb_r) && (d_s != a_msb_r);
`endif
        end else begin
          busy_s = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand, result and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      res_r    <= '0;
      bin_r    <= 1'b0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      ovf_r    <= 1'b0;
`endif
    end else begin
      a_r      <= a_s;
      b_r      <= b_s;
      res_r    <= res_s;
      bin_r    <= bin_s;
      cnt_r    <= cnt_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      diff_r   <= diff_s;
      borrow_r <= borrow_s;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_r  <= a_msb_s;
      b_msb_r  <= b_msb_s;
      ovf_r    <= ovf_s;
`endif
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.diff   = diff_r;
  assign bus.borrow = borrow_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign bus.overflow = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): table-driven vectors,
// a result scoreboard, and hand-written ignore-start and async-reset sequences.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) ifc ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  vec_t         vecs [8];
  exp_t         sb_q [$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_diff = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launches one operation and follows it to completion.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input exp_t e, input bit inject);
    int   busy_cnt;
    int   extra;
    bit   seen;
    exp_t got;
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.a     = av;
    ifc.b     = bv;
    sb_q.push_back(e);
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.a     = ~av;
    ifc.b     = ~bv;
    check("busy_after_start", ifc.busy, 1);
    busy_cnt = 1;
    seen     = 1'b0;
    for (int c = 0; c < 4 * W && !seen; c++) begin
      check("diff_held", ifc.diff, last_diff);
      if (inject && busy_cnt == 4) begin
        ifc.start = 1'b1;
        ifc.a     = 8'h11;
        ifc.b     = 8'h22;
      end
      @(negedge clk);
      ifc.start = 1'b0;
      if (ifc.done) begin
        seen = 1'b1;
      end else if (ifc.busy) begin
        busy_cnt++;
      end
    end
    got = sb_q.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected done within %0d cycles", 4 * W);
    end else begin
      check("diff", ifc.diff, got.diff);
      check("borrow", ifc.borrow, got.borrow);
`ifdef SERIAL_SUB_OVERFLOW_EN
      check("overflow", ifc.overflow, got.ovf);
`endif
      check("busy_low_at_done", ifc.busy, 0);
      last_diff = got.diff;
    end
    check("busy_cycles", busy_cnt, W);
    @(negedge clk);
    check("done_pulse_width", ifc.done, 0);
    extra = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (ifc.done || ifc.busy) extra++;
    end
    check("no_spurious_activity", extra, 0);
    check("diff_stable_after", ifc.diff, last_diff);
  endtask

  initial begin
    exp_t         e;
    logic [W:0]   wide;
    logic [W-1:0] ra, rb;

    rst_n     = 1'b0;
    ifc.start = 1'b0;
    ifc.a     = '0;
    ifc.b     = '0;
    #12;
    check("reset_busy", ifc.busy, 0);
    check("reset_done", ifc.done, 0);
    check("reset_diff", ifc.diff, 0);
    check("reset_borrow", ifc.borrow, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("reset_overflow", ifc.overflow, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{8'd200, 8'd55,  8'd145, 1'b0, 1'b0};
    vecs[1] = '{8'd5,   8'd10,  8'hFB,  1'b1, 1'b0};
    vecs[2] = '{8'h3C,  8'h3C,  8'h00,  1'b0, 1'b0};
    vecs[3] = '{8'h00,  8'hFF,  8'h01,  1'b1, 1'b0};
    vecs[4] = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1};
    vecs[5] = '{8'h10,  8'h01,  8'h0F,  1'b0, 1'b0};
    vecs[6] = '{8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1};
    vecs[7] = '{8'hFF,  8'h00,  8'hFF,  1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      e.diff   = vecs[i].diff;
      e.borrow = vecs[i].borrow;
      e.ovf    = vecs[i].ovf;
      run_op(vecs[i].a, vecs[i].b, e, 1'b0);
    end

    // Second start during the 4th SHIFT cycle must be ignored.
    e = '{8'd145, 1'b0, 1'b0};
    run_op(8'd200, 8'd55, e, 1'b1);

    for (int i = 0; i < 4; i++) begin
      ra       = W'($urandom);
      rb       = W'($urandom);
      wide     = {1'b0, ra} - {1'b0, rb};
      e.diff   = wide[W-1:0];
      e.borrow = (ra < rb);
      e.ovf    = (ra[W-1] != rb[W-1]) && (wide[W-1] != ra[W-1]);
      run_op(ra, rb, e, 1'b0);
    end

    // Leave a nonzero result, then reset asynchronously mid-SHIFT.
    e = '{8'h80, 1'b1, 1'b1};
    run_op(8'h7F, 8'hFF, e, 1'b0);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.a     = 8'hAA;
    ifc.b     = 8'h11;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", ifc.busy, 0);
    check("midreset_done", ifc.done, 0);
    check("midreset_diff", ifc.diff, 0);
    check("midreset_borrow", ifc.borrow, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("midreset_overflow", ifc.overflow, 0);
`endif
    @(negedge clk);
    rst_n     = 1'b1;
    last_diff = '0;
    e = '{8'd6, 1'b0, 1'b0};
    run_op(8'd9, 8'd3, e, 1'b0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
